// File: rtl/spi_cmem_bridge.sv
// SPI slave (mode 0) that bridges Raspberry Pi byte transactions onto a nibble-wide
// command-memory port: command byte {op, addr}, then auto-incrementing write or read data bytes.
module spi_cmem_bridge (
  input  logic       clk200,
  input  logic       reset,
  input  logic       SPI_SCK,
  input  logic       SPI_CS_n,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       spi_read,
  output logic       spi_write,
  output logic [3:0] spi_address,
  output logic [3:0] spi_out_cmem_in,
  input  logic [3:0] spi_in_cmem_out
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA,
    DISCARD
  } state_e;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  state_e      state_q, state_d;
  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        cap_q, cap_d;
  logic [3:0]  spi_address_q, spi_address_d;
  logic [3:0]  wdata_q, wdata_d;

  logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit, byte_done;
  logic [7:0]  rx_byte;

  // Stage 0/1 form the synchronizer; stage 2 is only used for edge detection.
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], SPI_SCK};
    cs_sync_d   = {cs_sync_q[1:0], SPI_CS_n};
    mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};
    sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
    cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    mosi_bit    = mosi_sync_q[1];
    rx_byte     = {rx_shift_q, mosi_bit};
    byte_done   = sck_rise && (bit_cnt_q == 3'd7) && (state_q != IDLE);
  end

  always_ff @(posedge clk200) begin
    if (reset) begin
      state_q       <= IDLE;
      sck_sync_q    <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      addr_q        <= '0;
      miso_q        <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      cap_q         <= 1'b0;
      spi_address_q <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      addr_q        <= addr_d;
      miso_q        <= miso_d;
      read_q        <= read_d;
      write_q       <= write_d;
      cap_q         <= cap_d;
      spi_address_q <= spi_address_d;
      wdata_q       <= wdata_d;
    end
  end

  // A CS_n rise wins over everything, including a coincident final SCK rise.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD: begin
          if (byte_done) begin
            case (rx_byte[7:4])
              OP_WRITE: state_d = WR_DATA;
              OP_READ:  state_d = RD_DATA;
              default:  state_d = DISCARD;
            endcase
          end
        end
        WR_DATA: state_d = WR_DATA;
        RD_DATA: state_d = RD_DATA;
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    addr_d        = addr_q;
    miso_d        = miso_q;
    read_d        = 1'b0;
    write_d       = 1'b0;
    cap_d         = read_q;
    spi_address_d = spi_address_q;
    wdata_d       = wdata_q;

    if (cs_rise) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      cap_d     = 1'b0;
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
      end
    end else begin
      if (sck_rise) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_shift_d = {rx_shift_q[5:0], mosi_bit};
      end
      if (byte_done) begin
        case (state_q)
          CMD: begin
            addr_d = rx_byte[3:0];
            if (rx_byte[7:4] == OP_READ) begin
              read_d        = 1'b1;
              spi_address_d = rx_byte[3:0];
            end
          end
          WR_DATA: begin
            write_d       = 1'b1;
            spi_address_d = addr_q;
            wdata_d       = rx_byte[3:0];
            addr_d        = addr_q + 4'd1;
          end
          RD_DATA: begin
            read_d        = 1'b1;
            spi_address_d = addr_q + 4'd1;
            addr_d        = addr_q + 4'd1;
          end
          default: ;
        endcase
      end
      if (state_q == RD_DATA) begin
        if (sck_fall) begin
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        // Read data lands two cycles after the boundary, well before the next SCK fall.
        if (cap_q) tx_shift_d = {4'b0000, spi_in_cmem_out};
      end
    end
  end

  assign SPI_MISO        = miso_q;
  assign spi_read        = read_q;
  assign spi_write       = write_q;
  assign spi_address     = spi_address_q;
  assign spi_out_cmem_in = wdata_q;

endmodule

// File: doc/spi_cmem_bridge.md
SPI_CMEM_BRIDGE -- requirements
Module: spi_cmem_bridge

Interface
REQ-001 clk200  input  1  system clock, 200 MHz; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on clk200 rising edge.
REQ-003 SPI_SCK  input  1  SPI clock from Raspberry Pi, asynchronous, mode 0, max clk200/10.
REQ-004 SPI_CS_n  input  1  SPI chip select, active-low, asynchronous.
REQ-005 SPI_MOSI  input  1  SPI data in, MSB first, asynchronous.
REQ-006 SPI_MISO  output  1  SPI data out, MSB first; driven low whenever no read data is being shifted.
REQ-007 spi_read  output  1  one-cycle pulse requesting a command-memory read.
REQ-008 spi_write  output  1  one-cycle pulse requesting a command-memory write.
REQ-009 spi_address  output  4  nibble register address, valid while spi_read or spi_write is high.
REQ-010 spi_out_cmem_in  output  4  write data nibble, valid while spi_write is high.
REQ-011 spi_in_cmem_out  input  4  read data, valid on the clk200 cycle after the spi_read pulse.

Function
REQ-012 SPI_SCK, SPI_CS_n and SPI_MOSI shall each pass through a 2-flop synchronizer; edge detection shall use a third stage.
REQ-013 MOSI shall be sampled on each synchronized SCK rising edge; MISO shall change only on synchronized SCK falling edges, or on CS_n falling.
REQ-014 FSM states: IDLE, CMD, WR_DATA, RD_DATA, DISCARD; a 3-bit bit counter shall wrap 7->0 at each byte boundary.
REQ-015 IDLE->CMD on the synchronized CS_n falling edge; bit counter := 0, MISO := 0.
REQ-016 Byte 1 (command) = {op[3:0], addr[3:0]}. On its 8th SCK rise: op 4'h1 -> WR_DATA, op 4'h2 -> RD_DATA, any other op -> DISCARD; the address register := addr.
REQ-017 WR_DATA: on the 8th SCK rise of each data byte, pulse spi_write for one cycle with spi_address = address register and spi_out_cmem_in = byte[3:0]; byte[7:4] ignored.
REQ-018 RD_DATA: on entry from CMD, and at each subsequent data-byte boundary, pulse spi_read for one cycle with the current address; capture spi_in_cmem_out on the following cycle into the MISO shift register as {4'b0000, data}.
REQ-019 The captured read byte shall be presented MSB first, starting at the first SCK fall after the boundary; MOSI bits received during RD_DATA shall be ignored.
REQ-020 Auto-increment: after each completed data byte in WR_DATA or RD_DATA, the address register := address + 1 mod 16 (15 wraps to 0); the op persists until CS_n rises.
REQ-021 In RD_DATA, the read pulse for the next address shall issue at the boundary; a read issued for a byte that CS_n aborts is permitted and harmless.
REQ-022 DISCARD: no spi_read or spi_write pulses; MISO held at 0 until CS_n rises.
REQ-023 CMD and WR_DATA shall issue no spi_read pulse; MISO = 0 during the command byte.
REQ-024 A synchronized CS_n rise in any state shall return the FSM to IDLE on that cycle; a partial byte shall be dropped with no pulse; MISO := 0.
REQ-025 spi_read and spi_write shall never both be high, and neither shall be high for two consecutive cycles.
REQ-026 A CS_n rise coincident with the 8th SCK rise shall be treated as an abort: no pulse.

Reset
REQ-027 On reset: FSM = IDLE, bit counter = 0, address register = 0, shift registers = 0, SPI_MISO = 0, spi_read = 0, spi_write = 0, spi_address = 0, spi_out_cmem_in = 0, and synchronizer flops = idle levels (SCK 0, CS_n 1, MOSI 0).
REQ-028 Reset asserted mid-transaction shall abort it with no pulse; the next CS_n fall shall start a fresh command byte.

Verification
REQ-029 Write: CS low, bytes 0x1B, 0x05 -> exactly one spi_write with address 0xB and data 0x5; no spi_read.
REQ-030 Read: cmem model returns 0x9 at address 0xC; CS low, bytes 0x2C, 0x00 -> one spi_read at 0xC at the first boundary; MISO byte 2 = 0x09.
REQ-031 Auto-increment wrap: bytes 0x1F, 0x01, 0x02, 0x03 -> writes (0xF,1), (0x0,2), (0x1,3); a read burst of 0x2E plus 3 data bytes issues reads at 0xE, 0xF, 0x0, 0x1.
REQ-032 Abort: bytes 0x13, then 5 bits, then CS_n high -> no spi_write; the next transaction 0x14, 0x07 writes (0x4,7).
REQ-033 Unknown op: bytes 0x7A, 0xFF -> no pulses; MISO stays 0 for the whole transaction.
REQ-034 Reset mid-read: reset pulses during byte 2 of a 0x25 read -> outputs at reset values; a following 0x15, 0x0A write completes normally.
